usb_utm_bus_ctrl: RTL and testbench

USB_UTM_BUS_CTRL -- requirements
Module: usb_utm_bus_ctrl

---
 rtl/usb_utmi_pkg.sv | 23 ++
 rtl/usb_utm_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_usb_utm_bus_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI definitions: line-state encoding, bus-state encoding and
// default bus-event timing at 48 MHz.
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } utmi_line_state_t;

  typedef enum logic [1:0] {
    ACTIVE_S  = 2'b00,
    RESET_S   = 2'b01,
    SUSPEND_S = 2'b10,
    RESUME_S  = 2'b11
  } usb_bus_state_t;

  localparam int unsigned USB_RESET_DET_CYC   = 120;     // 2.5 us
  localparam int unsigned USB_SUSPEND_DET_CYC = 144000;  // 3 ms
  localparam int unsigned USB_RESUME_DET_CYC  = 240;     // 5 us

endpackage

// File: rtl/usb_utm_bus_ctrl.sv
// USB bus-event controller: detects reset, suspend and resume from the UTM
// line state using a single line-stability timer and a four-state FSM.
module usb_utm_bus_ctrl
  import usb_utmi_pkg::*;
#(
  parameter int unsigned RESET_DET_CYC   = USB_RESET_DET_CYC,
  parameter int unsigned SUSPEND_DET_CYC = USB_SUSPEND_DET_CYC,
  parameter int unsigned RESUME_DET_CYC  = USB_RESUME_DET_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] line_state,
  input  logic       rx_active,
  output logic       suspend_m,
  output logic       usb_reset,
  output logic       usb_suspend,
  output logic       usb_resume,
  output logic [1:0] bus_state
);

  localparam logic [17:0] TMR_MAX     = '1;
  localparam logic [17:0] RESET_THR   = 18'(RESET_DET_CYC - 1);
  localparam logic [17:0] SUSPEND_THR = 18'(SUSPEND_DET_CYC - 1);
  localparam logic [17:0] RESUME_THR  = 18'(RESUME_DET_CYC - 1);

  logic [1:0]     r_line_q;
  logic [17:0]    r_tmr;
  logic [17:0]    w_tmr;
  logic           w_restart;
  logic           w_se0_det;
  logic           w_idle_det;
  logic           w_k_det;
  usb_bus_state_t r_state;
  usb_bus_state_t w_state_d;
  usb_bus_state_t r_bus_state;
  logic           r_suspend_m;
  logic           r_usb_reset;
  logic           r_usb_suspend;
  logic           r_usb_resume;

  // w_tmr is the stable-cycle count including the current cycle's line value,
  // so a change cycle evaluates as 0 rather than the previous run length.
  always_comb begin
    w_restart = (line_state != r_line_q) || rx_active;
    if (w_restart) begin
      w_tmr = '0;
    end else if (r_tmr == TMR_MAX) begin
      w_tmr = TMR_MAX;
    end else begin
      w_tmr = r_tmr + 18'd1;
    end
    w_se0_det  = (line_state == LS_SE0) && (w_tmr >= RESET_THR);
    w_idle_det = (line_state == LS_J)   && (w_tmr >= SUSPEND_THR);
    w_k_det    = (line_state == LS_K)   && (w_tmr >= RESUME_THR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_q <= LS_J;
      r_tmr    <= '0;
    end else begin
      r_line_q <= line_state;
      r_tmr    <= w_tmr;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ACTIVE_S: begin
        if (w_se0_det) begin
          w_state_d = RESET_S;
        end else if (w_idle_det) begin
          w_state_d = SUSPEND_S;
        end
      end
      RESET_S: begin
        if (line_state != LS_SE0) begin
          w_state_d = ACTIVE_S;
        end
      end
      SUSPEND_S: begin
        if (w_se0_det) begin
          w_state_d = RESET_S;
        end else if (w_k_det) begin
          w_state_d = RESUME_S;
        end
      end
      RESUME_S: begin
        // K and the short SE0 of the resume EOP hold here until J.
        if (w_se0_det) begin
          w_state_d = RESET_S;
        end else if (line_state == LS_J) begin
          w_state_d = ACTIVE_S;
        end
      end
      default: w_state_d = ACTIVE_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACTIVE_S;
    end else begin
      r_state <= w_state_d;
    end
  end

  // r_bus_state holds the previous r_state, which marks resume entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_state   <= ACTIVE_S;
      r_suspend_m   <= 1'b1;
      r_usb_reset   <= 1'b0;
      r_usb_suspend <= 1'b0;
      r_usb_resume  <= 1'b0;
    end else begin
      r_bus_state   <= r_state;
      r_suspend_m   <= (r_state != SUSPEND_S);
      r_usb_reset   <= (r_state == RESET_S);
      r_usb_suspend <= (r_state == SUSPEND_S);
      r_usb_resume  <= (r_state == RESUME_S) && (r_bus_state != RESUME_S);
    end
  end

  assign suspend_m   = r_suspend_m;
  assign usb_reset   = r_usb_reset;
  assign usb_suspend = r_usb_suspend;
  assign usb_resume  = r_usb_resume;
  assign bus_state   = r_bus_state;

endmodule

// File: tb/tb_usb_utm_bus_ctrl.sv
// Scoreboard bench for usb_utm_bus_ctrl: expected output vectors are queued
// against absolute cycle numbers and compared at the falling edge.
module tb_usb_utm_bus_ctrl;
  import usb_utmi_pkg::*;

  localparam int unsigned RST_CYC = 120;
  localparam int unsigned SUS_CYC = 2000;
  localparam int unsigned RES_CYC = 240;

  // {bus_state, usb_reset, usb_suspend, suspend_m, usb_resume}
  localparam logic [5:0] E_ACT   = {2'(ACTIVE_S),  4'b0010};
  localparam logic [5:0] E_RST   = {2'(RESET_S),   4'b1010};
  localparam logic [5:0] E_SUS   = {2'(SUSPEND_S), 4'b0100};
  localparam logic [5:0] E_RES_P = {2'(RESUME_S),  4'b0011};
  localparam logic [5:0] E_RES   = {2'(RESUME_S),  4'b0010};

  typedef struct {
    int         cyc;
    string      tag;
    logic [5:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] line_state;
  logic       rx_active;
  logic       suspend_m;
  logic       usb_reset;
  logic       usb_suspend;
  logic       usb_resume;
  logic [1:0] bus_state;
  logic [5:0] w_obs;

  exp_t sb_q[$];
  exp_t sb_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   t0;
  int   t1;
  int   p;

  usb_utm_bus_ctrl #(
    .RESET_DET_CYC  (RST_CYC),
    .SUSPEND_DET_CYC(SUS_CYC),
    .RESUME_DET_CYC (RES_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_state (line_state),
    .rx_active  (rx_active),
    .suspend_m  (suspend_m),
    .usb_reset  (usb_reset),
    .usb_suspend(usb_suspend),
    .usb_resume (usb_resume),
    .bus_state  (bus_state)
  );

  assign w_obs = {bus_state, usb_reset, usb_suspend, suspend_m, usb_resume};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [5:0] e);
    sb_q.push_back('{c, tag, e});
  endtask

  task automatic hold(input logic [1:0] ls, input logic rxa, input int n);
    for (int i = 0; i < n; i++) begin
      line_state = ls;
      rx_active  = rxa;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_vec("drain", 6'(sb_q.size()), 6'd0);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      sb_e = sb_q.pop_front();
      check_vec(sb_e.tag, w_obs, sb_e.exp);
    end
  end

  initial begin
    line_state = LS_J;
    rx_active  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_vals", w_obs, E_ACT);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SE0 one cycle short of reset.
    t0 = cyc;
    for (int k = 1; k <= 124; k++) push(t0 + k, "se0_119", E_ACT);
    hold(LS_SE0, 1'b0, RST_CYC - 1);
    hold(LS_J, 1'b0, 5);

    // SE0 exactly long enough for reset, then J.
    t0 = cyc;
    push(t0 + 120, "rst_pre", E_ACT);
    push(t0 + 121, "rst_on", E_RST);
    push(t0 + 122, "rst_off", E_ACT);
    hold(LS_SE0, 1'b0, RST_CYC);
    hold(LS_J, 1'b0, 10);

    // SE1 is ignored and restarts the timer inside an SE0 run.
    t0 = cyc;
    for (int k = 1; k <= 296; k++) push(t0 + k, "se1_split", E_ACT);
    hold(LS_SE1, 1'b0, 130);
    hold(LS_SE0, 1'b0, 60);
    hold(LS_SE1, 1'b0, 1);
    hold(LS_SE0, 1'b0, 100);
    hold(LS_J, 1'b0, 5);

    // Idle with an rx_active pulse delays suspend by a full interval.
    hold(LS_K, 1'b0, 1);
    t1 = cyc;
    p  = t1 + 1001;
    push(t1 + SUS_CYC + 1, "sus_rx_blk", E_ACT);
    push(p + SUS_CYC - 1, "sus_rx_pre", E_ACT);
    push(p + SUS_CYC, "sus_rx_on", E_SUS);
    push(p + SUS_CYC + 2, "sus_rx_hold", E_SUS);
    hold(LS_J, 1'b0, 1000);
    hold(LS_J, 1'b1, 1);
    hold(LS_J, 1'b0, SUS_CYC + 3);

    // Resume by K, then resume EOP (two SE0) and J.
    t0 = cyc;
    push(t0 + 240, "res_pre", E_SUS);
    push(t0 + 241, "res_pulse", E_RES_P);
    push(t0 + 242, "res_eop0", E_RES);
    push(t0 + 243, "res_eop1", E_RES);
    for (int k = 244; k <= 252; k++) push(t0 + k, "res_active", E_ACT);
    hold(LS_K, 1'b0, RES_CYC);
    hold(LS_SE0, 1'b0, 2);
    hold(LS_J, 1'b0, 10);

    // Plain idle into suspend.
    hold(LS_K, 1'b0, 1);
    t1 = cyc;
    push(t1 + SUS_CYC, "sus_pre", E_ACT);
    push(t1 + SUS_CYC + 1, "sus_on", E_SUS);
    push(t1 + SUS_CYC + 3, "sus_hold", E_SUS);
    hold(LS_J, 1'b0, SUS_CYC + 3);

    // Bus reset from suspend.
    t0 = cyc;
    push(t0 + 120, "sus_se0_pre", E_SUS);
    push(t0 + 121, "sus_se0_rst", E_RST);
    push(t0 + 122, "sus_se0_act", E_ACT);
    hold(LS_SE0, 1'b0, RST_CYC);
    hold(LS_J, 1'b0, 5);

    // Asynchronous reset while suspended.
    hold(LS_K, 1'b0, 1);
    t1 = cyc;
    push(t1 + SUS_CYC + 1, "sus2_on", E_SUS);
    hold(LS_J, 1'b0, SUS_CYC + 3);
    drain();
    #1 rst_n = 1'b0;
    #1 check_vec("arst_sus", w_obs, E_ACT);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    push(t0 + 5, "arst_sus_post", E_ACT);

    // Asynchronous reset while in bus reset.
    push(t0 + 122, "rst2_on", E_RST);
    hold(LS_SE0, 1'b0, RST_CYC + 5);
    drain();
    #1 rst_n = 1'b0;
    #1 check_vec("arst_rst", w_obs, E_ACT);
    line_state = LS_J;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    push(t0 + 3, "arst_rst_post", E_ACT);
    hold(LS_J, 1'b0, 5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
